cm0_dbg_ap: RTL and testbench
=============================

Name: cm0_dbg_ap

Overview:
- Debug access port (MEM-AP style) that sits directly upstream of the debug sub-module's SLV port and drives its slv_* transaction interface.
- Takes register-level requests from the debug port (SW-DP/JTAG-DP side) and converts DRW/BDx accesses into single SLV bus transfers.
- Holds the CSW, TAR and IDR registers; handles auto-increment and sticky error.
- One transfer outstanding at a time.

Parameters:
- IDR_VALUE, 32'h0477_0021, read-only value returned at offset 0xFC.
- AHBSLV, 1, when 0 every DRW/BDx access completes immediately with ap_err_o=1 and no SLV transfer.

Ports:
- dclk  in  1  debug clock.
- dbg_reset  in  1  synchronous active-high reset.
- ap_req_i  in  1  register access request from the debug port.
- ap_ready_o  out  1  AP can accept a request; request accepted on a dclk edge where ap_req_i && ap_ready_o.
- ap_write_i  in  1  write not read.
- ap_addr_i  in  6  register offset [7:2].
- ap_wdata_i  in  32  register write data.
- ap_abort_i  in  1  abort any not-yet-accepted bus transfer.
- ap_ack_o  out  1  one-cycle completion pulse.
- ap_rdata_o  out  32  read data; valid while ap_ack_o=1, held afterwards.
- ap_err_o  out  1  completion had an error; valid with ap_ack_o.
- slv_addr_o  out  32  SLV address.
- slv_size_o  out  2  SLV size: 00 byte, 01 half, 10 word.
- slv_trans_o  out  2  2'b10 NONSEQ in address phase, 2'b00 otherwise.
- slv_wdata_o  out  32  SLV write data, held from accept until completion.
- slv_write_o  out  1  SLV write not read.
- slv_rdata_i  in  32  SLV read data.
- slv_ready_i  in  1  SLV ready.
- slv_resp_i  in  1  SLV error response.

Behaviour:
- Clock and reset: one clock (dclk). dbg_reset is synchronous and active-high.
- Reset values: state IDLE; all outputs 0 except ap_ready_o=1; CSW.Size=2 (word); CSW.AddrInc=00; CSW.Sticky=0; TAR=0.
- Register map (offset):
  - 0x00 CSW: [2:0] Size, [5:4] AddrInc, [6] TrInProg (read-only), [7] Sticky (write-1-to-clear).
  - 0x04 TAR.
  - 0x0C DRW.
  - 0xFC IDR.
  - All other offsets read 0, ignore writes, ack with no error.
- CSW writes: Size values 3..7 are stored as 2. AddrInc values 1x are stored as 00.
- FSM states: IDLE, ADDR, DATA. ap_ready_o = (state==IDLE).
- IDLE, non-bus register access: the register is updated or read at the accept edge; ap_ack_o=1 on the following cycle (1-cycle latency).
- IDLE, DRW access:
  - If Sticky=1 or AHBSLV=0: no SLV transfer; ack with err on the next cycle.
  - Otherwise go to ADDR and drive slv_trans_o=10, slv_addr_o=TAR, slv_size_o=Size, slv_write_o; capture ap_wdata_i into slv_wdata_o.
- ADDR:
  - Hold address-phase signals until an edge with slv_ready_i=1, then go to DATA with slv_trans_o=00.
  - ap_abort_i=1 (sampled before acceptance) returns to IDLE with ap_ack_o=1 and ap_err_o=1. Sticky is not set and TAR is unchanged.
- DATA:
  - ap_abort_i is ignored; the bus phase cannot be cancelled.
  - On an edge with slv_ready_i=1: capture slv_rdata_i into ap_rdata_o (reads), set ap_err_o=slv_resp_i, Sticky|=slv_resp_i, pulse ap_ack_o and return to IDLE.
- Auto-increment:
  - On error-free completion with AddrInc=01, TAR[9:0] += 1/2/4 for Size 0/1/2.
  - The addition wraps modulo 1 KB; TAR[31:10] is unchanged.
  - No increment on error or abort.
- TrInProg=1 in ADDR and DATA.
- Simultaneous events:
  - A CSW write of Sticky=1 in the same cycle as an error completion cannot happen, because requests are only accepted in IDLE.
  - dbg_reset in any state returns to IDLE on the next edge, with slv_trans_o=00 immediately after that edge.

Optional Feature:
- Macro: CM0_DBG_AP_BD_EN.
- Defined: offsets 0x10/0x14/0x18/0x1C are BD0..BD3.
  - Access address is {TAR[31:4], n[1:0], 2'b00}, always word size.
  - Never auto-increments. Same FSM, sticky and error rules as DRW.
- Undefined: those offsets read 0, ignore writes, ack with no error.

Decomposition:
- Package cm0_dbg_ap_pkg holds:
  - state enum (IDLE/ADDR/DATA);
  - register offset constants (CSW, TAR, DRW, BD0, IDR);
  - SLV trans/size encodings;
  - CSW field bit positions.
- One natural sub-module: cm0_dbg_ap_tar_inc, a combinational TAR increment with 1 KB wrap.

Test Plan:
- Reset, then read IDR at 0xFC -> ap_ack_o one cycle after accept, ap_rdata_o=32'h0477_0021, ap_err_o=0; then read CSW -> 32'h0000_0002.
- CSW=0x12 (word, inc), TAR=0x2000_03FC, two DRW writes of 0xA5A5_A5A5 with slv_ready_i held 1 -> SLV addresses 0x2000_03FC then 0x2000_0000 (wrap), TAR reads back 0x2000_0004.
- DRW read with slv_ready_i low for 3 cycles in DATA, rdata=0xDEAD_BEEF -> ap_ack_o exactly one cycle after ready, ap_rdata_o=0xDEAD_BEEF, ap_ready_o low throughout.
- DRW read completing with slv_resp_i=1 -> ap_err_o=1, CSW[7]=1, TAR unchanged. Next DRW -> ack with err and no slv_trans_o activity. Write CSW with bit7=1 -> sticky cleared.
- DRW write with slv_ready_i=0 in ADDR, assert ap_abort_i -> return to IDLE, ack with err, Sticky=0. Repeat with abort asserted in DATA -> transfer completes normally.
- With CM0_DBG_AP_BD_EN, TAR=0x1000_0008, read BD2 -> slv_addr_o=0x1000_0008, slv_size_o=10, TAR unchanged. Without the macro -> ack, data 0, no SLV transfer.

Source files
------------

// File: rtl/cm0_dbg_ap_pkg.sv
// Shared encodings for the cm0 debug access port: FSM states, register offsets,
// SLV bus encodings and CSW field positions.
package cm0_dbg_ap_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_DATA = 2'd2;

  // Offsets are word indices, i.e. byte offset [7:2]
  localparam logic [5:0] OFS_CSW = 6'h00;
  localparam logic [5:0] OFS_TAR = 6'h01;
  localparam logic [5:0] OFS_DRW = 6'h03;
  localparam logic [5:0] OFS_BD0 = 6'h04;
  localparam logic [5:0] OFS_IDR = 6'h3F;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int CSW_SIZE_LSB   = 0;
  localparam int CSW_INC_LSB    = 4;
  localparam int CSW_TIP_BIT    = 6;
  localparam int CSW_STICKY_BIT = 7;

  function automatic logic [31:0] csw_pack(input logic [2:0] size, input logic [1:0] inc,
                                           input logic tip, input logic sticky);
    logic [31:0] v;
    v = '0;
    v[CSW_SIZE_LSB +: 3] = size;
    v[CSW_INC_LSB +: 2]  = inc;
    v[CSW_TIP_BIT]       = tip;
    v[CSW_STICKY_BIT]    = sticky;
    return v;
  endfunction

endpackage

// File: rtl/cm0_dbg_ap_tar_inc.sv
// Next TAR after an auto-incrementing access: adds 1/2/4 bytes to TAR[9:0],
// wrapping inside the current 1 KB page; TAR[31:10] passes through.
module cm0_dbg_ap_tar_inc (
  input  logic [31:0] tar_i,
  input  logic [1:0]  size_i,
  output logic [31:0] tar_o
);

  logic [9:0] step;

  assign step  = 10'd1 << size_i;
  assign tar_o = {tar_i[31:10], tar_i[9:0] + step};

endmodule

// File: rtl/cm0_dbg_ap.sv
// MEM-AP style debug access port: register accesses ack one cycle after accept, DRW/BDx issue one
// SLV transfer (ap_ready_o low until it completes). BD0..BD3 exist only with CM0_DBG_AP_BD_EN.
module cm0_dbg_ap #(
  parameter logic [31:0] IDR_VALUE = 32'h0477_0021,
  parameter bit          AHBSLV    = 1'b1
) (
  input  logic        dclk,
  input  logic        dbg_reset,
  input  logic        ap_req_i,
  output logic        ap_ready_o,
  input  logic        ap_write_i,
  input  logic [5:0]  ap_addr_i,
  input  logic [31:0] ap_wdata_i,
  input  logic        ap_abort_i,
  output logic        ap_ack_o,
  output logic [31:0] ap_rdata_o,
  output logic        ap_err_o,
  output logic [31:0] slv_addr_o,
  output logic [1:0]  slv_size_o,
  output logic [1:0]  slv_trans_o,
  output logic [31:0] slv_wdata_o,
  output logic        slv_write_o,
  input  logic [31:0] slv_rdata_i,
  input  logic        slv_ready_i,
  input  logic        slv_resp_i
);

  import cm0_dbg_ap_pkg::*;

  state_t      state_q, state_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  inc_q, inc_d;
  logic        sticky_q, sticky_d;
  logic [31:0] tar_q, tar_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] slv_addr_q, slv_addr_d;
  logic [1:0]  slv_size_q, slv_size_d;
  logic        slv_write_q, slv_write_d;
  logic [31:0] slv_wdata_q, slv_wdata_d;
  logic        drw_q, drw_d;

  logic        is_drw;
  logic        is_bd;
  logic        is_bus;
  logic [31:0] tar_next;
  logic [31:0] reg_rdata;

  assign is_drw = (ap_addr_i == OFS_DRW);
`ifdef CM0_DBG_AP_BD_EN
  assign is_bd  = (ap_addr_i[5:2] == OFS_BD0[5:2]);
`else
  assign is_bd  = 1'b0;
`endif
  assign is_bus = is_drw | is_bd;

  cm0_dbg_ap_tar_inc u_tar_inc (
    .tar_i  (tar_q),
    .size_i (size_q[1:0]),
    .tar_o  (tar_next)
  );

  always_comb begin
    reg_rdata = '0;
    case (ap_addr_i)
      OFS_CSW: reg_rdata = csw_pack(size_q, inc_q, state_q != ST_IDLE, sticky_q);
      OFS_TAR: reg_rdata = tar_q;
      OFS_IDR: reg_rdata = IDR_VALUE;
      default: reg_rdata = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    inc_d       = inc_q;
    sticky_d    = sticky_q;
    tar_d       = tar_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    slv_addr_d  = slv_addr_q;
    slv_size_d  = slv_size_q;
    slv_write_d = slv_write_q;
    slv_wdata_d = slv_wdata_q;
    drw_d       = drw_q;

    case (state_q)
      ST_IDLE: begin
        if (ap_req_i) begin
          if (is_bus) begin
            if (sticky_q || !AHBSLV) begin
              ack_d = 1'b1;
              err_d = 1'b1;
            end else begin
              state_d     = ST_ADDR;
              slv_addr_d  = is_bd ? {tar_q[31:4], ap_addr_i[1:0], 2'b00} : tar_q;
              slv_size_d  = is_bd ? SIZE_WORD : size_q[1:0];
              slv_write_d = ap_write_i;
              slv_wdata_d = ap_wdata_i;
              drw_d       = ~is_bd;
            end
          end else begin
            ack_d = 1'b1;
            if (!ap_write_i) begin
              rdata_d = reg_rdata;
            end else if (ap_addr_i == OFS_CSW) begin
              // Reserved Size/AddrInc encodings collapse to word / no-increment
              size_d = (ap_wdata_i[2:0] > 3'd2) ? 3'd2 : ap_wdata_i[2:0];
              inc_d  = ap_wdata_i[5] ? 2'b00 : ap_wdata_i[5:4];
              if (ap_wdata_i[CSW_STICKY_BIT]) sticky_d = 1'b0;
            end else if (ap_addr_i == OFS_TAR) begin
              tar_d = ap_wdata_i;
            end
          end
        end
      end
      ST_ADDR: begin
        // Once the slave takes the address phase the abort is too late
        if (slv_ready_i) begin
          state_d = ST_DATA;
        end else if (ap_abort_i) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end
      end
      ST_DATA: begin
        if (slv_ready_i) begin
          state_d  = ST_IDLE;
          ack_d    = 1'b1;
          err_d    = slv_resp_i;
          sticky_d = sticky_q | slv_resp_i;
          if (!slv_write_q) rdata_d = slv_rdata_i;
          if (!slv_resp_i && drw_q && inc_q == 2'b01) tar_d = tar_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (dbg_reset) begin
      state_q     <= ST_IDLE;
      size_q      <= 3'd2;
      inc_q       <= 2'b00;
      sticky_q    <= 1'b0;
      tar_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      slv_addr_q  <= '0;
      slv_size_q  <= '0;
      slv_write_q <= 1'b0;
      slv_wdata_q <= '0;
      drw_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      inc_q       <= inc_d;
      sticky_q    <= sticky_d;
      tar_q       <= tar_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      slv_addr_q  <= slv_addr_d;
      slv_size_q  <= slv_size_d;
      slv_write_q <= slv_write_d;
      slv_wdata_q <= slv_wdata_d;
      drw_q       <= drw_d;
    end
  end

  assign ap_ready_o  = (state_q == ST_IDLE);
  assign ap_ack_o    = ack_q;
  assign ap_err_o    = err_q;
  assign ap_rdata_o  = rdata_q;
  assign slv_trans_o = (state_q == ST_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
  assign slv_addr_o  = slv_addr_q;
  assign slv_size_o  = slv_size_q;
  assign slv_write_o = slv_write_q;
  assign slv_wdata_o = slv_wdata_q;

endmodule

// File: tb/tb_cm0_dbg_ap.sv
// Randomized scoreboard bench for cm0_dbg_ap against an abstract register/TAR model.
module tb_cm0_dbg_ap;

  logic        dclk = 1'b0;
  logic        dbg_reset = 1'b1;
  logic        ap_req_i = 1'b0;
  logic        ap_ready_o;
  logic        ap_write_i = 1'b0;
  logic [5:0]  ap_addr_i = '0;
  logic [31:0] ap_wdata_i = '0;
  logic        ap_abort_i = 1'b0;
  logic        ap_ack_o;
  logic [31:0] ap_rdata_o;
  logic        ap_err_o;
  logic [31:0] slv_addr_o;
  logic [1:0]  slv_size_o;
  logic [1:0]  slv_trans_o;
  logic [31:0] slv_wdata_o;
  logic        slv_write_o;
  logic [31:0] slv_rdata_i = '0;
  logic        slv_ready_i = 1'b0;
  logic        slv_resp_i = 1'b0;

  always #5 dclk = ~dclk;

  cm0_dbg_ap dut (
    .dclk(dclk), .dbg_reset(dbg_reset),
    .ap_req_i(ap_req_i), .ap_ready_o(ap_ready_o), .ap_write_i(ap_write_i),
    .ap_addr_i(ap_addr_i), .ap_wdata_i(ap_wdata_i), .ap_abort_i(ap_abort_i),
    .ap_ack_o(ap_ack_o), .ap_rdata_o(ap_rdata_o), .ap_err_o(ap_err_o),
    .slv_addr_o(slv_addr_o), .slv_size_o(slv_size_o), .slv_trans_o(slv_trans_o),
    .slv_wdata_o(slv_wdata_o), .slv_write_o(slv_write_o), .slv_rdata_i(slv_rdata_i),
    .slv_ready_i(slv_ready_i), .slv_resp_i(slv_resp_i)
  );

  typedef struct packed { logic [31:0] rdata; logic err; logic rd; } ack_t;
  typedef struct packed { logic [31:0] addr; logic [1:0] size; logic wr; logic [31:0] wdata; } slv_t;

  ack_t ack_q[$];
  slv_t slv_q[$];
  int total = 0;
  int bad = 0;

  // Abstract model of the AP's architectural registers
  logic [2:0]  m_size;
  logic [1:0]  m_inc;
  logic        m_sticky;
  logic [31:0] m_tar;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a);
    case (a)
      6'h00:   return {24'h0, m_sticky, 1'b0, m_inc, 1'b0, m_size};
      6'h01:   return m_tar;
      6'h3F:   return 32'h0477_0021;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_size = 3'd2; m_inc = 2'b00; m_sticky = 1'b0; m_tar = 32'h0;
  endtask

  always @(negedge dclk) begin
    ack_t e;
    slv_t s;
    if (!dbg_reset && ap_ack_o) begin
      if (ack_q.size() == 0) begin
        total++; bad++;
        $display("FAIL ack_unexpected: got ack=1 want no ack");
      end else begin
        e = ack_q.pop_front();
        check("ack_err", {31'h0, ap_err_o}, {31'h0, e.err});
        if (e.rd) check("ack_rdata", ap_rdata_o, e.rdata);
      end
    end
    if (!dbg_reset && slv_trans_o == 2'b10 && slv_ready_i) begin
      if (slv_q.size() == 0) begin
        total++; bad++;
        $display("FAIL slv_unexpected: got NONSEQ addr=%h want no transfer", slv_addr_o);
      end else begin
        s = slv_q.pop_front();
        check("slv_addr", slv_addr_o, s.addr);
        check("slv_size", {30'h0, slv_size_o}, {30'h0, s.size});
        check("slv_write", {31'h0, slv_write_o}, {31'h0, s.wr});
        if (s.wr) check("slv_wdata", slv_wdata_o, s.wdata);
      end
    end
  end

  // One full AP access; caller is always at posedge+1 with the AP idle
  task automatic access(input bit wr, input logic [5:0] a, input logic [31:0] wd,
                        input int aw, input int dw, input bit resp,
                        input bit ab_addr, input bit ab_data, input logic [31:0] rd);
    bit bus, drw;
    logic [31:0] ba;
    logic [1:0] bs;
    ack_t e;
    slv_t s;
    bus = 0; drw = 0; ba = '0; bs = '0;
    if (a == 6'h03) begin
      bus = 1; drw = 1; ba = m_tar; bs = m_size[1:0];
    end
`ifdef CM0_DBG_AP_BD_EN
    else if (a >= 6'h04 && a <= 6'h07) begin
      bus = 1; ba = {m_tar[31:4], 4'h0} + {26'h0, a[1:0], 4'h0} / 4; bs = 2'b10;
    end
`endif
    check("ready_idle", {31'h0, ap_ready_o}, 32'h1);
    ap_req_i = 1; ap_write_i = wr; ap_addr_i = a; ap_wdata_i = wd;
    @(posedge dclk); #1;
    ap_req_i = 0; ap_wdata_i = $urandom;

    if (!bus || m_sticky) begin
      e.err = bus;
      e.rd = !wr && !bus;
      e.rdata = m_read(a);
      if (!bus && wr && a == 6'h00) begin
        m_size = (wd[2:0] > 3'd2) ? 3'd2 : wd[2:0];
        m_inc = (wd[5:4] == 2'b01) ? 2'b01 : 2'b00;
        if (wd[7]) m_sticky = 0;
      end else if (!bus && wr && a == 6'h01) begin
        m_tar = wd;
      end
      ack_q.push_back(e);
      @(negedge dclk);
      check("ack_lat1", {31'h0, ap_ack_o}, 32'h1);
      check("no_slv", {30'h0, slv_trans_o}, 32'h0);
      @(posedge dclk); #1;
      return;
    end

    s.addr = ba; s.size = bs; s.wr = wr; s.wdata = wd;
    slv_q.push_back(s);
    check("addr_phase", {30'h0, slv_trans_o}, 32'h2);
    for (int i = 0; i < aw; i++) begin
      slv_ready_i = 0;
      ap_abort_i = ab_addr && (i == aw - 1);
      check("busy_addr", {31'h0, ap_ready_o}, 32'h0);
      @(posedge dclk); #1;
    end
    ap_abort_i = 0;
    if (ab_addr && aw > 0) begin
      s = slv_q.pop_back();
      e.rdata = '0; e.err = 1; e.rd = 0;
      ack_q.push_back(e);
      check("abort_ack", {31'h0, ap_ack_o}, 32'h1);
      check("abort_trans", {30'h0, slv_trans_o}, 32'h0);
      @(posedge dclk); #1;
      return;
    end
    slv_ready_i = 1;
    @(posedge dclk); #1;
    for (int i = 0; i < dw; i++) begin
      slv_ready_i = 0;
      ap_abort_i = ab_data;
      check("busy_data", {31'h0, ap_ready_o}, 32'h0);
      @(posedge dclk); #1;
    end
    ap_abort_i = 0;
    slv_ready_i = 1; slv_rdata_i = rd; slv_resp_i = resp;
    e.rdata = rd; e.err = resp; e.rd = !wr;
    ack_q.push_back(e);
    if (resp) m_sticky = 1;
    else if (drw && m_inc == 2'b01)
      m_tar = (m_tar & 32'hFFFF_FC00) | ((m_tar + (32'd1 << m_size)) & 32'h0000_03FF);
    @(posedge dclk); #1;
    check("ack_lat", {31'h0, ap_ack_o}, 32'h1);
    slv_ready_i = 0; slv_resp_i = 0; slv_rdata_i = $urandom;
    @(posedge dclk); #1;
    check("ack_pulse", {31'h0, ap_ack_o}, 32'h0);
  endtask

  initial begin
    logic [5:0] a;
    int op, aw;
    m_reset();
    repeat (3) @(posedge dclk);
    #1 dbg_reset = 0;
    check("rst_ready", {31'h0, ap_ready_o}, 32'h1);
    check("rst_ack", {31'h0, ap_ack_o}, 32'h0);
    check("rst_trans", {30'h0, slv_trans_o}, 32'h0);
    check("rst_addr", slv_addr_o, 32'h0);
    check("rst_rdata", ap_rdata_o, 32'h0);

    access(0, 6'h3F, 0, 0, 0, 0, 0, 0, 0);
    access(0, 6'h00, 0, 0, 0, 0, 0, 0, 0);
    access(1, 6'h00, 32'h12, 0, 0, 0, 0, 0, 0);
    access(1, 6'h01, 32'h2000_03FC, 0, 0, 0, 0, 0, 0);
    access(1, 6'h03, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0);
    access(1, 6'h03, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0);
    access(0, 6'h01, 0, 0, 0, 0, 0, 0, 0);
    access(0, 6'h03, 0, 0, 3, 0, 0, 0, 32'hDEAD_BEEF);
    access(0, 6'h03, 0, 1, 1, 1, 0, 0, 32'h1234_5678);
    access(0, 6'h00, 0, 0, 0, 0, 0, 0, 0);
    access(0, 6'h01, 0, 0, 0, 0, 0, 0, 0);
    access(0, 6'h03, 0, 0, 0, 0, 0, 0, 0);
    access(1, 6'h00, 32'h92, 0, 0, 0, 0, 0, 0);
    access(0, 6'h00, 0, 0, 0, 0, 0, 0, 0);
    access(1, 6'h03, 32'h0BAD_F00D, 2, 0, 0, 1, 0, 0);
    access(0, 6'h00, 0, 0, 0, 0, 0, 0, 0);
    access(1, 6'h03, 32'h600D_CAFE, 1, 2, 0, 0, 1, 0);
    access(1, 6'h01, 32'h1000_0008, 0, 0, 0, 0, 0, 0);
    access(0, 6'h06, 0, 0, 0, 0, 0, 0, 32'hB0B0_0002);
    access(0, 6'h01, 0, 0, 0, 0, 0, 0, 0);

    // Reset while the address phase is pending
    ap_req_i = 1; ap_write_i = 0; ap_addr_i = 6'h03;
    @(posedge dclk); #1;
    ap_req_i = 0;
    check("pre_rst_trans", {30'h0, slv_trans_o}, 32'h2);
    dbg_reset = 1;
    @(posedge dclk); #1;
    check("mid_rst_trans", {30'h0, slv_trans_o}, 32'h0);
    check("mid_rst_ready", {31'h0, ap_ready_o}, 32'h1);
    dbg_reset = 0;
    m_reset();
    access(0, 6'h00, 0, 0, 0, 0, 0, 0, 0);
    access(0, 6'h01, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      aw = $urandom_range(0, 3);
      case (op)
        0: a = 6'h00;
        1: a = 6'h01;
        6: a = 6'(4 + $urandom_range(0, 3));
        7: a = 6'h3F;
        8: a = 6'($urandom_range(0, 1));
        9: a = ($urandom_range(0, 1) == 0) ? 6'h02 : 6'($urandom_range(8, 62));
        default: a = 6'h03;
      endcase
      access((op <= 1) ? 1'b1 : (op >= 7) ? 1'b0 : 1'($urandom_range(0, 1)),
             a, (op == 1) ? $urandom : $urandom & 32'hFF, aw, $urandom_range(0, 3),
             $urandom_range(0, 7) == 0, aw > 0 && $urandom_range(0, 5) == 0,
             1'($urandom_range(0, 1)), $urandom);
    end

    repeat (3) @(posedge dclk);
    check("ack_q_empty", ack_q.size(), 0);
    check("slv_q_empty", slv_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
